// File: rtl/serial_cmp_pkg.sv
// rtl/serial_cmp_pkg.sv - shared types and constants for the serial magnitude comparator
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 2;

  // Result code packed as {gt, lt, eq}; exactly one bit is set for a valid result.
  typedef logic [2:0] res_t;

  localparam res_t RES_EQ = 3'b001;
  localparam res_t RES_LT = 3'b010;
  localparam res_t RES_GT = 3'b100;

  function automatic res_t pack_res(input logic gt, input logic lt, input logic eq);
    return {gt, lt, eq};
  endfunction

endpackage

// File: rtl/serial_cmp_ctrl_comparator_2bit.sv
// rtl/serial_cmp_ctrl_comparator_2bit.sv - 2-bit unsigned magnitude comparator slice
module comparator_2bit (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       eq,
  output logic       lt,
  output logic       gt
);

  assign eq = (a == b);
  assign lt = (a < b);
  assign gt = (a > b);

endmodule

// File: rtl/serial_cmp_ctrl.sv
// rtl/serial_cmp_ctrl.sv - MSB-first serial compare of two WIDTH-bit operands, 2 bits per cycle
// Optional build macro: SERIAL_CMP_EARLY_EXIT_EN (finish on the first differing slice).
module serial_cmp_ctrl
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             lt,
  output logic             gt,
  output logic             busy
);

  localparam int NS    = WIDTH / SLICE_W;
  localparam int IDX_W = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NS - 1);

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [IDX_W-1:0]   idx;

  logic [SLICE_W-1:0] a_sl;
  logic [SLICE_W-1:0] b_sl;
  logic               sl_eq;
  logic               sl_lt;
  logic               sl_gt;
  res_t               sl_res;

`ifndef SERIAL_CMP_EARLY_EXIT_EN
  // First differing slice seen during a constant-latency walk.
  logic               sticky_vld;
  res_t               sticky_res;
`endif

  // Select the current 2-bit slice of both latched operands.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < NS; i++) begin
      if (idx == IDX_W'(i)) begin
        a_sl = a_q[SLICE_W*i +: SLICE_W];
        b_sl = b_q[SLICE_W*i +: SLICE_W];
      end
    end
  end

  comparator_2bit u_slice (
    .a  (a_sl),
    .b  (b_sl),
    .eq (sl_eq),
    .lt (sl_lt),
    .gt (sl_gt)
  );

  assign sl_res = pack_res(sl_gt, sl_lt, sl_eq);

  // Sequencer: accept a pair, walk slices MSB-first, hold the result until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      eq         <= 1'b0;
      lt         <= 1'b0;
      gt         <= 1'b0;
      busy       <= 1'b0;
      idx        <= IDX_TOP;
      a_q        <= '0;
      b_q        <= '0;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
      sticky_vld <= 1'b0;
      sticky_res <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q        <= a;
            b_q        <= b;
            idx        <= IDX_TOP;
            in_ready   <= 1'b0;
            busy       <= 1'b1;
            state      <= RUN;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
            sticky_vld <= 1'b0;
            sticky_res <= '0;
`endif
          end
        end

        RUN: begin
`ifdef SERIAL_CMP_EARLY_EXIT_EN
          // A differing slice decides the magnitude order; equal all the way down means eq.
          if (!sl_eq) begin
            {gt, lt, eq} <= sl_res;
            out_valid    <= 1'b1;
            state        <= DONE;
          end else if (idx == '0) begin
            {gt, lt, eq} <= RES_EQ;
            out_valid    <= 1'b1;
            state        <= DONE;
          end else begin
            idx <= idx - IDX_W'(1);
          end
`else
          // Always walk every slice; the first difference wins and is kept sticky.
          if (idx == '0) begin
            {gt, lt, eq} <= sticky_vld ? sticky_res : sl_res;
            out_valid    <= 1'b1;
            state        <= DONE;
          end else begin
            idx <= idx - IDX_W'(1);
            if (!sticky_vld && !sl_eq) begin
              sticky_vld <= 1'b1;
              sticky_res <= sl_res;
            end
          end
`endif
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            eq        <= 1'b0;
            lt        <= 1'b0;
            gt        <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// tb/tb_serial_cmp_ctrl.sv - scoreboard bench for serial_cmp_ctrl (WIDTH=8)
module tb_serial_cmp_ctrl;

  localparam int WIDTH = 8;
  localparam int NS    = WIDTH / 2;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic             eq;
  logic             lt;
  logic             gt;
  logic             busy;

  serial_cmp_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .eq        (eq),
    .lt        (lt),
    .gt        (gt),
    .busy      (busy)
  );

  typedef struct {
    logic [2:0] res;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc    = 0;
  int   or_mode = 0;   // 0 random, 1 held low, 2 held high

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
  endtask

  // Reference: plain unsigned compare; latency from the highest differing bit.
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    exp_t e;
    int   p;
    e.acc = 0;
    if (x == y) e.res = 3'b001;
    else if (x < y) e.res = 3'b010;
    else e.res = 3'b100;
    e.lat = NS;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    if (x != y) begin
      p = WIDTH - 1;
      while (x[p] == y[p]) p--;
      e.lat = NS - p / 2;
    end
`endif
    return e;
  endfunction

  // Consumer readiness driven away from the sampling edge.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        1: out_ready = 1'b0;
        2: out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: pops the scoreboard when a result appears and checks the handshake rules.
  logic       seen = 1'b0;
  logic       post_hs = 1'b0;
  logic [2:0] held = 3'b000;
  exp_t       cur;
  always @(negedge clk) begin
    if (rst) begin
      chk("reset_out_valid", out_valid, 0);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_flags", {gt, lt, eq}, 0);
      chk("reset_busy", busy, 0);
      seen    = 1'b0;
      post_hs = 1'b0;
    end else begin
      if (post_hs) begin
        chk("after_hs_in_ready", in_ready, 1);
        chk("after_hs_flags", {gt, lt, eq}, 0);
        chk("after_hs_busy", busy, 0);
        post_hs = 1'b0;
      end
      if (out_valid) begin
        if (!seen) begin
          if (sb.size() == 0) begin
            chk("unexpected_result", 1, 0);
          end else begin
            cur = sb.pop_front();
            chk("result_flags", {gt, lt, eq}, cur.res);
            chk("result_latency", cyc - cur.acc, cur.lat);
          end
          held = {gt, lt, eq};
          seen = 1'b1;
        end else begin
          chk("held_flags", {gt, lt, eq}, held);
        end
        chk("done_in_ready", in_ready, 0);
        if (out_ready) begin
          seen    = 1'b0;
          post_hs = 1'b1;
        end
      end
    end
  end

  // Offer a pair and keep in_valid high until accepted; optionally record the expectation.
  task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input bit expect_it);
    exp_t e;
    bit   ok;
    @(negedge clk);
    in_valid = 1'b1;
    a = x;
    b = y;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
    end else begin
      if (expect_it) begin
        e = model(x, y);
        e.acc = cyc + 1;
        sb.push_back(e);
      end
      @(posedge clk);
    end
  endtask

  task automatic release_in();
    @(negedge clk);
    in_valid = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
  endtask

  task automatic drain();
    for (int n = 0; n < 500 && sb.size() > 0; n++) @(negedge clk);
    chk("drain_empty", sb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Directed pairs with an always-ready consumer.
    or_mode = 2;
    send(8'hA5, 8'hA5, 1); release_in();
    send(8'h80, 8'h7F, 1); release_in();
    send(8'h12, 8'h13, 1); release_in();
    send(8'h00, 8'hFF, 1); release_in();
    drain();

    // Result backpressure for five cycles, then a single handshake.
    or_mode = 1;
    send(8'h55, 8'h54, 1); release_in();
    for (int n = 0; n < 50 && !out_valid; n++) @(negedge clk);
    chk("bp_valid_seen", out_valid, 1);
    repeat (5) @(negedge clk);
    chk("bp_still_valid", out_valid, 1);
    chk("bp_busy", busy, 1);
    or_mode = 2;
    drain();

    // New pair held on the input while the first is still running.
    send(8'hC3, 8'h3C, 1);
    send(8'h01, 8'h02, 1);
    release_in();
    drain();

    // Reset two cycles into a compare discards it.
    send(8'hF0, 8'hF1, 0);
    release_in();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_busy", busy, 0);
    repeat (10) @(negedge clk);
    chk("post_rst_no_result", out_valid, 0);

    // Randomised pairs against a random consumer.
    or_mode = 0;
    for (int i = 0; i < 40; i++) begin
      x = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0: y = x;
        1: y = x ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
        default: y = WIDTH'($urandom);
      endcase
      send(x, y, 1);
      if ($urandom_range(0, 1) == 0) release_in();
    end
    release_in();
    or_mode = 2;
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
